// File: rtl/move_arbiter.sv
// Button front-end for the room-navigation FSM: arbitrates N/S/E/W presses into one strobe per press,
// waits for release, applies a cooldown, tracks the vorpal flag and counts moves. Define ROUND_ROBIN_EN for rotating priority.
module move_arbiter #(
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_n,
    input  logic             btn_s,
    input  logic             btn_e,
    input  logic             btn_w,
    input  logic             in_stash,
    input  logic             game_over,
    output logic             n,
    output logic             s,
    output logic             e,
    output logic             w,
    output logic             v,
    output logic             busy,
    output logic [CNT_W-1:0] moves
);

    localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_REL = 2'd2,
        COOL     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [1:0]       r_grant;
    logic [1:0]       w_pick;
    logic [3:0]       w_btn;
    logic             w_any;
    logic             w_grant_en;
    logic             w_issue;
    logic [CNT_W-1:0] r_moves;
    logic             r_v;

    // Bit index doubles as the direction code: 0=N, 1=S, 2=E, 3=W.
    assign w_btn      = {btn_w, btn_e, btn_s, btn_n};
    assign w_any      = |w_btn;
    assign w_grant_en = (r_state == IDLE) && !game_over && w_any;

`ifdef ROUND_ROBIN_EN
    logic [1:0] r_rr;
    logic [1:0] w_idx;

    // Walk from the farthest candidate back to r_rr so the closest pressed button wins.
    always_comb begin
        w_pick = r_rr;
        w_idx  = r_rr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr + 2'(k);
            if (w_btn[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr <= 2'd0;
        end else if (w_grant_en) begin
            r_rr <= w_pick + 2'd1;
        end
    end
`else
    always_comb begin
        w_pick = 2'd3;
        if (btn_n) begin
            w_pick = 2'd0;
        end else if (btn_s) begin
            w_pick = 2'd1;
        end else if (btn_e) begin
            w_pick = 2'd2;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (game_over) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    w_state_nxt = WAIT_REL;
                end
                WAIT_REL: begin
                    if (!w_any) begin
                        if (COOLDOWN_CYCLES == 0) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = COOL;
                            w_cnt_nxt   = CW'(COOLDOWN_CYCLES - 1);
                        end
                    end
                end
                COOL: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Grant is pure data: it is only observed while in ISSUE, which always follows a load.
    always_ff @(posedge clk) begin
        if (w_grant_en) begin
            r_grant <= w_pick;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_moves <= '0;
            r_v     <= 1'b0;
        end else begin
            if (in_stash) begin
                r_v <= 1'b1;
            end
            if ((r_state == ISSUE) && !game_over && (r_moves != '1)) begin
                r_moves <= r_moves + CNT_W'(1);
            end
        end
    end

    // game_over masks the strobe in the same cycle, so a pending grant never leaks out.
    assign w_issue = (r_state == ISSUE) && !game_over;
    assign n       = w_issue && (r_grant == 2'd0);
    assign s       = w_issue && (r_grant == 2'd1);
    assign e       = w_issue && (r_grant == 2'd2);
    assign w       = w_issue && (r_grant == 2'd3);
    assign v       = r_v;
    assign busy    = (r_state != IDLE);
    assign moves   = r_moves;

endmodule
